// File: rtl/encoder_axi_multi.sv
// encoder_axi_multi: NUM_CH quadrature decoders (x4) behind an AXI4-Lite slave.
//
// Ports
//   clk, reset              single clock, async active-high reset
//   enc_a, enc_b [NUM_CH]   raw quadrature inputs, asynchronous
//   aw_*/w_*/B_*            AXI4-Lite write address / data / response
//   ar_*/R_*                AXI4-Lite read address / data
//
// Register map (addr[11:0], ch n base = n*0x10)
//   +0x0 COUNT  RW (byte strobes, bits >= CNT_W ignored)
//   +0x4 CTRL   bit0 EN, bit1 REV
//   +0x8 STAT   bit0 DIR (RO), bit1 OVF, bit2 UNF, bit3 ILL (W1C)
//   0x100 INFO  {16'h0E4C, CNT_W[7:0], NUM_CH[7:0]}

// Per-channel decoder: synchroniser, x4 step decode, counter and flags.
module encoder_axi_multi_ch #(
    parameter int CNT_W   = 32,
    parameter int SYNC_FF = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             wr_count,
    input  logic             wr_ctrl,
    input  logic             wr_stat,
    input  logic [31:0]      w_data,
    input  logic [3:0]       w_strb,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       ctrl,
    output logic [3:0]       stat
);
    logic [SYNC_FF-1:0] sync_a, sync_b;
    logic [1:0]         prev_ab, cur_ab, cur_idx, prev_idx, diff;
    logic               step_up, step_dn, step_ill, cnt_up, cnt_dn, step_ok;
    logic               dir, ovf, unf, ill;
    logic [CNT_W:0]     inc, dec;
    logic [CNT_W-1:0]   wr_val;
    logic [3:1]         clr;

    assign cur_ab = {sync_a[SYNC_FF-1], sync_b[SYNC_FF-1]};

    // Map the Gray sequence 00,01,11,10 onto 0,1,2,3 so a step is a mod-4 difference.
    assign cur_idx  = {cur_ab[1], ^cur_ab};
    assign prev_idx = {prev_ab[1], ^prev_ab};
    assign diff     = cur_idx - prev_idx;
    assign step_up  = (diff == 2'd1);
    assign step_dn  = (diff == 2'd3);
    assign step_ill = (diff == 2'd2);
    assign cnt_up   = ctrl[1] ? step_dn : step_up;
    assign cnt_dn   = ctrl[1] ? step_up : step_dn;
    // A bus write to COUNT wins; the coincident step is dropped entirely.
    assign step_ok  = ctrl[0] & ~wr_count;

    assign inc = {1'b0, count} + 1'b1;
    assign dec = {1'b0, count} - 1'b1;
    assign clr = (wr_stat & w_strb[0]) ? w_data[3:1] : 3'b000;
    assign stat = {ill, unf, ovf, dir};

    always_comb begin
        wr_val = count;
        for (int i = 0; i < CNT_W; i++)
            if (w_strb[i/8]) wr_val[i] = w_data[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a  <= '0;
            sync_b  <= '0;
            prev_ab <= 2'b00;
            count   <= '0;
            ctrl    <= 2'b00;
            dir     <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            ill     <= 1'b0;
        end else begin
            sync_a  <= {sync_a[SYNC_FF-2:0], enc_a};
            sync_b  <= {sync_b[SYNC_FF-2:0], enc_b};
            // Tracking continues while disabled so re-enable never sees a burst.
            prev_ab <= cur_ab;
            if (wr_count)
                count <= wr_val;
            else if (step_ok && cnt_up)
                count <= inc[CNT_W-1:0];
            else if (step_ok && cnt_dn)
                count <= dec[CNT_W-1:0];
            if (wr_ctrl && w_strb[0])
                ctrl <= w_data[1:0];
            if (step_ok && cnt_up)
                dir <= 1'b1;
            else if (step_ok && cnt_dn)
                dir <= 1'b0;
            // Set beats a same-cycle W1C of the same bit.
            ovf <= (ovf & ~clr[1]) | (step_ok & cnt_up & inc[CNT_W]);
            unf <= (unf & ~clr[2]) | (step_ok & cnt_dn & dec[CNT_W]);
            ill <= (ill & ~clr[3]) | (step_ok & step_ill);
        end
    end
endmodule

module encoder_axi_multi #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int SYNC_FF = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enc_a,
    input  logic [NUM_CH-1:0] enc_b,
    input  logic [31:0]       aw_addr,
    input  logic              aw_valid,
    output logic              AW_READY,
    input  logic [31:0]       w_data,
    input  logic [3:0]        w_strb,
    input  logic              w_valid,
    output logic              W_READY,
    output logic [1:0]        B_RESP,
    output logic              B_VALID,
    input  logic              b_ready,
    input  logic [31:0]       ar_addr,
    input  logic              ar_valid,
    output logic              AR_READY,
    output logic [31:0]       R_DATA,
    output logic [1:0]        R_RESP,
    output logic              R_VALID,
    input  logic              r_ready
);
    localparam logic [4:0]  NUM_CH_L = 5'(NUM_CH);
    localparam logic [31:0] INFO     = {16'h0E4C, 8'(CNT_W), 8'(NUM_CH)};

    typedef enum logic [1:0] {WR_IDLE, WR_ACCEPT, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_ACCEPT, RD_VALID} rd_state_t;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic [NUM_CH-1:0][CNT_W-1:0] ch_count;
    logic [NUM_CH-1:0][1:0]       ch_ctrl;
    logic [NUM_CH-1:0][3:0]       ch_stat;
    logic [NUM_CH-1:0]            wr_count, wr_ctrl, wr_stat;

    logic        wr_hs, rd_hs, wr_in_ch, wr_info, rd_in_ch, rd_info;
    logic [31:0] rd_val;
    logic        unused_addr;

    assign unused_addr = ^{aw_addr[31:12], ar_addr[31:12]};

    // READY is a decoded state flop: one registered pulse per accepted beat.
    assign AW_READY = (wr_state == WR_ACCEPT);
    assign W_READY  = (wr_state == WR_ACCEPT);
    assign B_VALID  = (wr_state == WR_RESP);
    assign AR_READY = (rd_state == RD_ACCEPT);
    assign R_VALID  = (rd_state == RD_VALID);

    assign wr_hs = AW_READY & aw_valid & w_valid;
    assign rd_hs = AR_READY & ar_valid;

    // Channel space is 0x000..0x0FF; offset 0xC and misaligned addresses are holes.
    assign wr_in_ch = (aw_addr[11:8] == 4'h0) && ({1'b0, aw_addr[7:4]} < NUM_CH_L)
                   && (aw_addr[1:0] == 2'b00) && (aw_addr[3:2] != 2'b11);
    assign wr_info  = (aw_addr[11:0] == 12'h100);
    assign rd_in_ch = (ar_addr[11:8] == 4'h0) && ({1'b0, ar_addr[7:4]} < NUM_CH_L)
                   && (ar_addr[1:0] == 2'b00) && (ar_addr[3:2] != 2'b11);
    assign rd_info  = (ar_addr[11:0] == 12'h100);

    always_comb begin
        wr_count = '0;
        wr_ctrl  = '0;
        wr_stat  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_hs && wr_in_ch && aw_addr[7:4] == 4'(i)) begin
                case (aw_addr[3:2])
                    2'd0:    wr_count[i] = 1'b1;
                    2'd1:    wr_ctrl[i]  = 1'b1;
                    2'd2:    wr_stat[i]  = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (rd_info) rd_val = INFO;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_in_ch && ar_addr[7:4] == 4'(i)) begin
                case (ar_addr[3:2])
                    2'd0:    rd_val[CNT_W-1:0] = ch_count[i];
                    2'd1:    rd_val[1:0]       = ch_ctrl[i];
                    2'd2:    rd_val[3:0]       = ch_stat[i];
                    default: ;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        encoder_axi_multi_ch #(.CNT_W(CNT_W), .SYNC_FF(SYNC_FF)) u_ch (
            .clk      (clk),
            .reset    (reset),
            .enc_a    (enc_a[i]),
            .enc_b    (enc_b[i]),
            .wr_count (wr_count[i]),
            .wr_ctrl  (wr_ctrl[i]),
            .wr_stat  (wr_stat[i]),
            .w_data   (w_data),
            .w_strb   (w_strb),
            .count    (ch_count[i]),
            .ctrl     (ch_ctrl[i]),
            .stat     (ch_stat[i])
        );
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE:   if (aw_valid && w_valid) wr_next = WR_ACCEPT;
            WR_ACCEPT: wr_next = (aw_valid && w_valid) ? WR_RESP : WR_IDLE;
            WR_RESP:   if (b_ready) wr_next = WR_IDLE;
            default:   wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE:   if (ar_valid) rd_next = RD_ACCEPT;
            RD_ACCEPT: rd_next = ar_valid ? RD_VALID : RD_IDLE;
            RD_VALID:  if (r_ready) rd_next = RD_IDLE;
            default:   rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
            B_RESP   <= 2'b00;
            R_RESP   <= 2'b00;
            R_DATA   <= '0;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
            if (wr_hs) B_RESP <= (wr_in_ch || wr_info) ? 2'b00 : 2'b10;
            // Captured from current state, so a coincident write is not visible.
            if (rd_hs) begin
                R_RESP <= (rd_in_ch || rd_info) ? 2'b00 : 2'b10;
                R_DATA <= rd_val;
            end
        end
    end
endmodule
